// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_if
// Brief    : Core data-port and memory write-port signals of the store buffer.
//            slave  = store buffer view, master = core/memory side view.
// Revision : 1.0  initial release
// ============================================================================
interface store_buffer_if;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        output cpu_rdata, mem_valid, mem_addr, mem_wdata
    );

    modport master (
        output cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        input  cpu_rdata, mem_valid, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Posted-write FIFO between the core data port and a stallable
//            memory write port, with youngest-match load forwarding.
// Revision : 1.0  initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus,
    output logic           full,
    output logic           empty,
    output logic [CW-1:0]  count,
    output logic           overflow
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW-1:0] r_head;
    logic [c_AW-1:0] r_tail;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [29:0]     r_waddr [DEPTH];
    logic [31:0]     r_data  [DEPTH];

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_fwd_data;

    // Byte offset bits carry no meaning for word-granular stores.
    logic w_unused_offset;
    assign w_unused_offset = &{1'b0, bus.cpu_addr[1:0]};

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // Pop depends only on registered state and mem_ready; a pop frees the
    // slot a full-buffer push needs, so both may happen together.
    assign w_pop   = !w_empty && bus.mem_ready;
    assign w_push  = bus.cpu_we && (!w_full || w_pop);
    assign w_drop  = bus.cpu_we && w_full && !w_pop;

    // Entry storage: contents need no reset, validity comes from count.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_waddr[r_tail] <= bus.cpu_addr[31:2];
            r_data[r_tail]  <= bus.cpu_wdata;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head entry presentation: registers only, zeroed while empty.
    always_comb begin
        bus.mem_valid = !w_empty;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (!w_empty) begin
            bus.mem_addr  = {r_waddr[r_head], 2'b00};
            bus.mem_wdata = r_data[r_head];
        end
    end

    // Load forwarding: walk oldest to youngest so the last hit is the newest.
    always_comb begin
        w_fwd_data = bus.mem_rdata;
        w_idx      = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + c_AW'(i);
            if ((CW'(i) < r_count) && (r_waddr[w_idx] == bus.cpu_addr[31:2])) begin
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    assign bus.cpu_rdata = w_fwd_data;
    assign full          = w_full;
    assign empty         = w_empty;
    assign count         = r_count;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire
